// File: rtl/adder78_fault_checker.sv
// Checker downstream of the duplicated carry-select adder: registers the sum, its inverted
// duplicate and the parity-prediction bits, flags duplication/parity errors and tracks error history.
module adder78_fault_checker #(
  parameter int WIDTH     = 78,
  parameter int CNT_W     = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] s_invert,
  input  logic             papb,
  input  logic             pab,
  input  logic             clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             dup_err,
  output logic             par_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             alarm,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    NORMAL  = 2'b00,
    SUSPECT = 2'b01,
    ALARM   = 2'b10
  } state_e;

  localparam logic [3:0]       LIMIT   = 4'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Stage 1 registers
  logic             v1_q;
  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] sinv1_q;
  logic             papb1_q;
  logic             pab1_q;

  // Stage 2 / history registers
  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             dup_q;
  logic             par_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       cons_q;
  state_e           state_q;
  logic             alarm_q;

  // Check results for the sample currently held in stage 1
  logic             dup_d;
  logic             par_d;
  logic             err_d;
  logic [3:0]       cons_inc;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    dup_d    = (s1_q != ~sinv1_q);
    par_d    = ((^s1_q) != (papb1_q ^ pab1_q));
    err_d    = v1_q & (dup_d | par_d);
    cons_inc = cons_q + 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      s1_q    <= '0;
      sinv1_q <= '0;
      papb1_q <= 1'b0;
      pab1_q  <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        s1_q    <= s;
        sinv1_q <= s_invert;
        papb1_q <= papb;
        pab1_q  <= pab;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      dup_q       <= 1'b0;
      par_q       <= 1'b0;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        out_sum_q <= s1_q;
        dup_q     <= dup_d;
        par_q     <= par_d;
      end
    end
  end

  // clr outranks a same-cycle sample: the sample's flags still load above, but it is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      cons_q  <= 4'd0;
      state_q <= NORMAL;
      alarm_q <= 1'b0;
    end else if (clr) begin
      cnt_q   <= '0;
      cons_q  <= 4'd0;
      state_q <= NORMAL;
      alarm_q <= 1'b0;
    end else if (v1_q) begin
      if (err_d && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        NORMAL: begin
          if (err_d) begin
            cons_q  <= 4'd1;
            state_q <= (LIMIT == 4'd1) ? ALARM : SUSPECT;
            alarm_q <= (LIMIT == 4'd1);
          end
        end
        SUSPECT: begin
          if (err_d) begin
            cons_q <= cons_inc;
            if (cons_inc == LIMIT) begin
              state_q <= ALARM;
              alarm_q <= 1'b1;
            end
          end else begin
            cons_q  <= 4'd0;
            state_q <= NORMAL;
          end
        end
        ALARM: alarm_q <= 1'b1;
        default: begin
          cons_q  <= 4'd0;
          state_q <= NORMAL;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign dup_err   = dup_q;
  assign par_err   = par_q;
  assign err_cnt   = cnt_q;
  assign alarm     = alarm_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_adder78_fault_checker.sv
// Directed bench for adder78_fault_checker: a default instance plus a CNT_W=2 instance
// share one stimulus stream; expected values come from hand-built adder samples.
module tb_adder78_fault_checker;

  localparam int W = 78;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] s;
  logic [W-1:0] s_invert;
  logic         papb;
  logic         pab;
  logic         clr;

  logic         out_valid,  out_valid2;
  logic [W-1:0] out_sum,    out_sum2;
  logic         dup_err,    dup_err2;
  logic         par_err,    par_err2;
  logic [7:0]   err_cnt;
  logic [1:0]   err_cnt2;
  logic         alarm,      alarm2;
  logic [1:0]   fsm_state,  fsm_state2;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_sum [100];
  logic [W-1:0] vs, vi, c_sum;
  logic         vpa, vpb;

  always #5 clk = ~clk;

  adder78_fault_checker u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .s(s), .s_invert(s_invert),
    .papb(papb), .pab(pab), .clr(clr), .out_valid(out_valid), .out_sum(out_sum),
    .dup_err(dup_err), .par_err(par_err), .err_cnt(err_cnt), .alarm(alarm),
    .fsm_state(fsm_state)
  );

  adder78_fault_checker #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .s(s), .s_invert(s_invert),
    .papb(papb), .pab(pab), .clr(clr), .out_valid(out_valid2), .out_sum(out_sum2),
    .dup_err(dup_err2), .par_err(par_err2), .err_cnt(err_cnt2), .alarm(alarm2),
    .fsm_state(fsm_state2)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] sv, input logic [W-1:0] siv,
                       input logic pa, input logic pb);
    in_valid = v;
    s        = sv;
    s_invert = siv;
    papb     = pa;
    pab      = pb;
  endtask

  // Consistent adder output: s = a+b, s_invert = ~s, papb ^ pab equals parity of s.
  task automatic gen(output logic [W-1:0] sv, output logic [W-1:0] siv,
                     output logic pa, output logic pb);
    logic [95:0]  ra, rb;
    logic [W-1:0] a, b;
    ra  = {$urandom(), $urandom(), $urandom()};
    rb  = {$urandom(), $urandom(), $urandom()};
    a   = ra[W-1:0];
    b   = rb[W-1:0];
    sv  = a + b;
    siv = ~sv;
    pa  = (^a) ^ (^b);
    pb  = (^sv) ^ pa;
  endtask

  // One sample followed by one bubble; afterwards the outputs show that sample.
  task automatic push(input logic [W-1:0] sv, input logic [W-1:0] siv,
                      input logic pa, input logic pb);
    drive(1'b1, sv, siv, pa, pb);
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic push_par_fault();
    gen(vs, vi, vpa, vpb);
    vs[0] = ~vs[0];
    vi[0] = ~vi[0];
    push(vs, vi, vpa, vpb);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    clr   = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    step();
    step();
    check("rst_valid", out_valid, 0);
    check("rst_cnt",   err_cnt,   0);
    check("rst_state", fsm_state, 0);
    check("rst_alarm", alarm,     0);
    @(negedge clk) rst_n = 1'b1;
    #1;

    // 1: clean back-to-back stream, two-edge latency
    for (int i = 0; i < 102; i++) begin
      if (i < 100) begin
        gen(vs, vi, vpa, vpb);
        exp_sum[i] = vs;
        drive(1'b1, vs, vi, vpa, vpb);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i == 0) check("t1_latency", out_valid, 0);
      if (i >= 1 && i <= 100) begin
        check("t1_valid", out_valid, 1);
        check("t1_sum",   out_sum,   exp_sum[i-1]);
        check("t1_dup",   dup_err,   0);
        check("t1_par",   par_err,   0);
      end
    end
    check("t1_idle",  out_valid, 0);
    check("t1_cnt",   err_cnt,   0);
    check("t1_state", fsm_state, 0);

    // 2: s_invert-only fault, then a clean sample
    gen(vs, vi, vpa, vpb);
    vi[5] = ~vi[5];
    push(vs, vi, vpa, vpb);
    check("t2_sum",   out_sum,   vs);
    check("t2_dup",   dup_err,   1);
    check("t2_par",   par_err,   0);
    check("t2_cnt",   err_cnt,   1);
    check("t2_state", fsm_state, 1);
    gen(vs, vi, vpa, vpb);
    push(vs, vi, vpa, vpb);
    check("t2_dup_clean", dup_err,   0);
    check("t2_state_nrm", fsm_state, 0);
    check("t2_cnt_hold",  err_cnt,   1);

    // 3: three parity-only faults with an extra bubble between 2 and 3
    clr_pulse();
    check("t3_clr_cnt", err_cnt, 0);
    push_par_fault();
    check("t3_par1",   par_err,   1);
    check("t3_dup1",   dup_err,   0);
    check("t3_state1", fsm_state, 1);
    push_par_fault();
    check("t3_par2",   par_err,   1);
    check("t3_alarm2", alarm,     0);
    step();
    push_par_fault();
    check("t3_par3",   par_err,   1);
    check("t3_alarm3", alarm,     1);
    check("t3_state3", fsm_state, 2);
    check("t3_cnt3",   err_cnt,   3);
    gen(vs, vi, vpa, vpb);
    push(vs, vi, vpa, vpb);
    gen(vs, vi, vpa, vpb);
    push(vs, vi, vpa, vpb);
    check("t3_alarm_sticky", alarm,     1);
    check("t3_state_sticky", fsm_state, 2);
    check("t3_cnt_sticky",   err_cnt,   3);

    // 4: clr lands on the same edge an erroneous sample loads stage 2
    gen(vs, vi, vpa, vpb);
    vi[9] = ~vi[9];
    drive(1'b1, vs, vi, vpa, vpb);
    step();
    in_valid = 1'b0;
    clr      = 1'b1;
    step();
    clr = 1'b0;
    check("t4_valid", out_valid, 1);
    check("t4_dup",   dup_err,   1);
    check("t4_alarm", alarm,     0);
    check("t4_state", fsm_state, 0);
    check("t4_cnt",   err_cnt,   0);

    // 5: saturation of the 2-bit counter across alarm / clr cycles
    for (int k = 0; k < 3; k++) push_par_fault();
    check("t5_cnt2_3",  err_cnt2, 3);
    check("t5_alarm_on", alarm2,  1);
    push_par_fault();
    check("t5_cnt2_sat", err_cnt2, 3);
    check("t5_cnt_4",    err_cnt,  4);
    clr_pulse();
    check("t5_alarm_off", alarm2,   0);
    check("t5_cnt2_clr",  err_cnt2, 0);
    push_par_fault();
    push_par_fault();
    check("t5_cnt2_2",   err_cnt2,   2);
    check("t5_state2",   fsm_state2, 1);

    // 6: asynchronous reset with both stages full
    gen(vs, vi, vpa, vpb);
    vi[1] = ~vi[1];
    drive(1'b1, vs, vi, vpa, vpb);
    step();
    gen(vs, vi, vpa, vpb);
    drive(1'b1, vs, vi, vpa, vpb);
    step();
    check("t6_pre_valid", out_valid, 1);
    check("t6_pre_state", fsm_state, 2);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_sum",   out_sum,   0);
    check("t6_dup",   dup_err,   0);
    check("t6_par",   par_err,   0);
    check("t6_cnt",   err_cnt,   0);
    check("t6_cnt2",  err_cnt2,  0);
    check("t6_alarm", alarm,     0);
    check("t6_state", fsm_state, 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    gen(c_sum, vi, vpa, vpb);
    drive(1'b1, c_sum, vi, vpa, vpb);
    step();
    in_valid = 1'b0;
    check("t6_lat1", out_valid, 0);
    step();
    check("t6_lat2", out_valid, 1);
    check("t6_new",  out_sum,   c_sum);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
